// File: rtl/tbus_mem_responder_pkg.sv
// Shared tbus defines plus the package used by the memory responder.
`ifndef TBUS_DEFINES_SV
`define TBUS_DEFINES_SV
`define TBUS_OPTYPE_RANGE 1:0
`define TBUS_READ         2'b00
`define TBUS_WRITE        2'b01
`define TBUS_DATA_WIDTH   64
`endif

package tbus_mem_responder_pkg;

  localparam int TBUS_DW = `TBUS_DATA_WIDTH;

  typedef logic [`TBUS_OPTYPE_RANGE] tbus_op_t;

  // Request fields captured at accept time; the word index is kept separately
  // because its width depends on the array depth.
  typedef struct packed {
    tbus_op_t           op;
    logic               hit;
    logic [TBUS_DW-1:0] wdata;
    logic [TBUS_DW-1:0] wmask;
  } tbus_req_t;

  // An offset from the base hits the array when it is below depth * 8 bytes.
  function automatic logic tbus_addr_hit(input logic [63:0] off, input int unsigned depth_log);
    return (off >> (depth_log + 3)) == 64'd0;
  endfunction

endpackage

// File: rtl/tbus_mem_array.sv
// Word-addressed flop array: combinational read port, bit-masked synchronous write port.
module tbus_mem_array #(
  parameter int DEPTH_LOG = 12,
  parameter int W         = 64
) (
  input  logic                 clock,
  input  logic [DEPTH_LOG-1:0] raddr,
  output logic [W-1:0]         rdata,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [W-1:0]         wmask
);

  logic [W-1:0] mem [0:(1<<DEPTH_LOG)-1];

  assign rdata = mem[raddr];

  // Merge only the enabled bits into the stored word; contents are never reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
  end

endmodule

// File: rtl/tbus_mem_responder.sv
// tbus target backed by a local word array; one request outstanding, fixed latency.
module tbus_mem_responder
  import tbus_mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG = 12,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tbus_index_valid,
  output logic                      tbus_index_ready,
  input  logic [63:0]               tbus_index,
  input  logic [TBUS_DW-1:0]        tbus_write_data,
  input  logic [TBUS_DW-1:0]        tbus_write_mask,
  input  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type,
  output logic [TBUS_DW-1:0]        tbus_read_data,
  output logic                      tbus_operation_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  tbus_req_t            req_q;
  logic [DEPTH_LOG-1:0] word_q;

  logic                 fire;
  logic [63:0]          in_off;
  logic                 in_hit;
  logic [DEPTH_LOG-1:0] in_word;
  logic [DEPTH_LOG-1:0] rd_word;
  logic [TBUS_DW-1:0]   arr_rdata;
  logic                 arr_we;

  assign fire    = tbus_index_valid & tbus_index_ready;
  assign in_off  = tbus_index - BASE_ADDR;
  assign in_hit  = tbus_addr_hit(in_off, DEPTH_LOG);
  assign in_word = in_off[DEPTH_LOG+2:3];

  // In IDLE the read port looks at the live request so a single-cycle latency
  // can capture data on the accept edge; otherwise it uses the latched word.
  assign rd_word = (state == ST_IDLE) ? in_word : word_q;

  // Writes commit on the edge that ends RESP; reset drops state out of RESP
  // immediately, so an interrupted write never lands.
  assign arr_we = (state == ST_RESP) && (req_q.op == `TBUS_WRITE) && req_q.hit;

  tbus_mem_array #(.DEPTH_LOG(DEPTH_LOG), .W(TBUS_DW)) u_array (
    .clock (clock),
    .raddr (rd_word),
    .rdata (arr_rdata),
    .we    (arr_we),
    .waddr (word_q),
    .wdata (req_q.wdata),
    .wmask (req_q.wmask)
  );

  // Request FSM with registered ready/done/read_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      req_q               <= '0;
      word_q              <= '0;
      tbus_index_ready    <= 1'b1;
      tbus_operation_done <= 1'b0;
      tbus_read_data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tbus_operation_done <= 1'b0;
          tbus_read_data      <= '0;
          if (fire) begin
            req_q            <= '{op: tbus_operation_type, hit: in_hit,
                                  wdata: tbus_write_data, wmask: tbus_write_mask};
            word_q           <= in_word;
            tbus_index_ready <= 1'b0;
            if (LATENCY == 1) begin
              state               <= ST_RESP;
              cnt                 <= '0;
              tbus_operation_done <= 1'b1;
              tbus_read_data      <= (tbus_operation_type == `TBUS_READ && in_hit) ? arr_rdata : '0;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          // Counter reaches zero on this edge, so the next cycle is RESP.
          if (cnt == 4'd1) begin
            state               <= ST_RESP;
            tbus_operation_done <= 1'b1;
            tbus_read_data      <= (req_q.op == `TBUS_READ && req_q.hit) ? arr_rdata : '0;
          end
        end
        ST_RESP: begin
          state               <= ST_IDLE;
          tbus_operation_done <= 1'b0;
          tbus_read_data      <= '0;
          tbus_index_ready    <= 1'b1;
        end
        default: begin
          state               <= ST_IDLE;
          tbus_operation_done <= 1'b0;
          tbus_read_data      <= '0;
          tbus_index_ready    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbus_mem_responder.sv
// Randomised bench for tbus_mem_responder against a word-array reference model.
`ifndef TBUS_READ
`define TBUS_READ  2'b00
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif

module tb_tbus_mem_responder;

  localparam int          DL   = 12;
  localparam int          NW   = 1 << DL;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [1:0]  RD   = `TBUS_READ;
  localparam logic [1:0]  WR   = `TBUS_WRITE;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        v0 = 0, rdy0, done0;
  logic [63:0] idx0 = 0, wd0 = 0, wm0 = 0, rd0;
  logic [1:0]  op0 = 0;
  logic        v1 = 0, rdy1, done1;
  logic [63:0] idx1 = 0, wd1 = 0, wm1 = 0, rd1;
  logic [1:0]  op1 = 0;

  tbus_mem_responder #(.DEPTH_LOG(DL), .LATENCY(2), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .tbus_index_valid(v0), .tbus_index_ready(rdy0), .tbus_index(idx0),
    .tbus_write_data(wd0), .tbus_write_mask(wm0), .tbus_operation_type(op0),
    .tbus_read_data(rd0), .tbus_operation_done(done0));

  tbus_mem_responder #(.DEPTH_LOG(DL), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clock(clock), .reset(reset),
    .tbus_index_valid(v1), .tbus_index_ready(rdy1), .tbus_index(idx1),
    .tbus_write_data(wd1), .tbus_write_mask(wm1), .tbus_operation_type(op1),
    .tbus_read_data(rd1), .tbus_operation_done(done1));

  int nvec = 0;
  int nerr = 0;
  logic [63:0] mem_m [NW];

  // Reference: applies one request to the model memory and returns the data a read should see.
  function automatic logic [63:0] ref_access(input logic [1:0] op, input logic [63:0] addr,
                                             input logic [63:0] data, input logic [63:0] mask);
    logic [63:0] off;
    logic [63:0] r;
    int w;
    off = addr - BASE;
    r   = 64'd0;
    if (off < 64'(NW) * 64'd8) begin
      w = int'(off / 64'd8);
      if (op == RD)      r = mem_m[w];
      else if (op == WR) mem_m[w] = (mem_m[w] & ~mask) | (data & mask);
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one request on the chosen port and wait (bounded) for done.
  task automatic issue(input bit sel, input logic [1:0] op, input logic [63:0] addr,
                       input logic [63:0] data, input logic [63:0] mask,
                       output logic [63:0] rdat, output int lat);
    @(negedge clock);
    if (sel) begin v1 = 1; op1 = op; idx1 = addr; wd1 = data; wm1 = mask; end
    else     begin v0 = 1; op0 = op; idx0 = addr; wd0 = data; wm0 = mask; end
    @(posedge clock); #1;
    v0 = 0; v1 = 0;
    lat  = -1;
    rdat = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (sel ? done1 : done0) begin
        lat  = c;
        rdat = sel ? rd1 : rd0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    nvec++; if (rdy0 !== 1'b1)   begin nerr++; $display("FAIL reset_ready: got %b want 1", rdy0); end
    nvec++; if (done0 !== 1'b0)  begin nerr++; $display("FAIL reset_done: got %b want 0", done0); end
    nvec++; if (rd0 !== 64'd0)   begin nerr++; $display("FAIL reset_rdata: got %h want 0", rd0); end
    nvec++; if (rdy1 !== 1'b1)   begin nerr++; $display("FAIL reset_ready1: got %b want 1", rdy1); end
    reset = 0;
    @(negedge clock);
    nvec++; if (rdy0 !== 1'b1 || done0 !== 1'b0)
      begin nerr++; $display("FAIL post_reset: ready %b done %b want 1 0", rdy0, done0); end
  endtask

  task automatic test_fill();
    logic [63:0] r, d;
    int lat;
    for (int w = 0; w < NW; w++) begin
      d = rnd64();
      issue(0, WR, BASE + 64'(w) * 8, d, ONES, r, lat);
      void'(ref_access(WR, BASE + 64'(w) * 8, d, ONES));
      nvec++; if (lat !== 2 || r !== 64'd0)
        begin nerr++; $display("FAIL fill_w%0d: lat %0d data %h want 2 0", w, lat, r); end
    end
  endtask

  task automatic test_write_read();
    logic [63:0] r;
    int lat;
    issue(0, WR, 64'h8000_0010, 64'h1122_3344_5566_7788, ONES, r, lat);
    void'(ref_access(WR, 64'h8000_0010, 64'h1122_3344_5566_7788, ONES));
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL wr_latency: got %0d want 2", lat); end
    nvec++; if (r !== 64'd0) begin nerr++; $display("FAIL wr_rdata: got %h want 0", r); end
    issue(0, RD, 64'h8000_0010, 64'd0, 64'd0, r, lat);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL rd_latency: got %0d want 2", lat); end
    nvec++; if (r !== 64'h1122_3344_5566_7788)
      begin nerr++; $display("FAIL rd_after_wr: got %h want 1122334455667788", r); end
  endtask

  task automatic test_masked();
    logic [63:0] r;
    int lat;
    issue(0, WR, BASE, ONES, ONES, r, lat);
    void'(ref_access(WR, BASE, ONES, ONES));
    issue(0, WR, BASE, 64'h0000_00AB_0000_0000, 64'h0000_00FF_0000_0000, r, lat);
    void'(ref_access(WR, BASE, 64'h0000_00AB_0000_0000, 64'h0000_00FF_0000_0000));
    issue(0, RD, BASE, 64'd0, 64'd0, r, lat);
    nvec++; if (r !== 64'hFFFF_FFAB_FFFF_FFFF)
      begin nerr++; $display("FAIL masked_byte: got %h want ffffffabffffffff", r); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [5];
    logic [63:0] expq [$];
    logic [63:0] e;
    int issued = 0, got = 0, last_done = -100;
    bit prev_fire = 0, prev_done = 0;
    for (int k = 0; k < 5; k++) addrs[k] = BASE + 64'($urandom_range(0, NW - 1)) * 8;
    @(negedge clock);
    v0 = 1; op0 = RD; idx0 = addrs[0];
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (prev_fire) begin
        nvec++; if (rdy0 !== 1'b0) begin nerr++; $display("FAIL b2b_ready_low c%0d: got %b", cyc, rdy0); end
      end
      if (prev_done) begin
        nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL b2b_ready_high c%0d: got %b", cyc, rdy0); end
      end
      prev_done = done0;
      if (done0) begin
        nvec++;
        if (expq.size() == 0) begin nerr++; $display("FAIL b2b_extra_done c%0d: got done want none", cyc); end
        else begin
          e = expq.pop_front();
          if (rd0 !== e) begin nerr++; $display("FAIL b2b_data c%0d: got %h want %h", cyc, rd0, e); end
        end
        if (got > 0) begin
          nvec++; if (cyc - last_done != 3)
            begin nerr++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last_done); end
        end
        last_done = cyc;
        got++;
      end
      prev_fire = v0 && rdy0;
      if (prev_fire) begin
        expq.push_back(ref_access(RD, idx0, 64'd0, 64'd0));
        issued++;
      end
      @(posedge clock); #1;
      if (prev_fire) begin
        if (issued < 5) idx0 = addrs[issued];
        else            v0 = 0;
      end
      @(negedge clock);
    end
    v0 = 0;
    nvec++; if (got !== 5) begin nerr++; $display("FAIL b2b_count: got %0d want 5", got); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] r;
    int lat;
    issue(0, RD, 64'h7FFF_FFF8, 64'd0, 64'd0, r, lat);
    nvec++; if (lat !== 2 || r !== 64'd0)
      begin nerr++; $display("FAIL oor_read: lat %0d data %h want 2 0", lat, r); end
    issue(0, WR, BASE + 64'h8000, rnd64(), ONES, r, lat);
    nvec++; if (lat !== 2 || r !== 64'd0)
      begin nerr++; $display("FAIL oor_write: lat %0d data %h want 2 0", lat, r); end
    issue(0, WR, BASE - 64'd8, rnd64(), ONES, r, lat);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL oor_write_low: lat %0d want 2", lat); end
  endtask

  task automatic test_random();
    logic [63:0] r, e, a, d, m;
    logic [1:0] op;
    int lat, sel;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)      a = BASE + 64'($urandom_range(0, NW - 1)) * 8 + 64'($urandom_range(0, 7));
      else if (sel < 9) a = BASE + 64'h8000 + 64'($urandom_range(0, 65535));
      else              a = BASE - 64'd1 - 64'($urandom_range(0, 65535));
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? RD : (sel < 8) ? WR : 2'($urandom_range(2, 3));
      d   = rnd64();
      sel = $urandom_range(0, 2);
      m   = (sel == 0) ? ONES : (sel == 1) ? rnd64() : (64'hFF << (8 * $urandom_range(0, 7)));
      issue(0, op, a, d, m, r, lat);
      e = ref_access(op, a, d, m);
      nvec++; if (lat !== 2) begin nerr++; $display("FAIL rand%0d_latency: got %0d want 2", i, lat); end
      nvec++; if (r !== e) begin nerr++; $display("FAIL rand%0d_data op%0d addr %h: got %h want %h", i, op, a, r, e); end
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] r, old;
    int lat;
    bit seen = 0;
    old = ref_access(RD, 64'h8000_0020, 64'd0, 64'd0);
    @(negedge clock);
    v0 = 1; op0 = WR; idx0 = 64'h8000_0020; wd0 = ~old; wm0 = ONES;
    @(posedge clock); #1;
    v0 = 0;
    @(negedge clock);
    if (done0) seen = 1;
    reset = 1;
    repeat (3) begin @(negedge clock); if (done0) seen = 1; end
    reset = 0;
    @(negedge clock);
    if (done0) seen = 1;
    nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL midop_ready: got %b want 1", rdy0); end
    nvec++; if (seen) begin nerr++; $display("FAIL midop_done: got done want none"); end
    issue(0, RD, 64'h8000_0020, 64'd0, 64'd0, r, lat);
    nvec++; if (r !== old) begin nerr++; $display("FAIL midop_nocommit: got %h want %h", r, old); end
  endtask

  task automatic test_latency1();
    logic [63:0] r, a, d;
    int lat;
    for (int i = 0; i < 8; i++) begin
      a = BASE + 64'($urandom_range(0, NW - 1)) * 8;
      d = rnd64();
      issue(1, WR, a, d, ONES, r, lat);
      nvec++; if (lat !== 1 || r !== 64'd0)
        begin nerr++; $display("FAIL l1_write%0d: lat %0d data %h want 1 0", i, lat, r); end
      @(negedge clock);
      v1 = 1; op1 = RD; idx1 = a;
      @(posedge clock); #1;
      v1 = 0;
      @(negedge clock);
      nvec++; if (done1 !== 1'b1 || rd1 !== d)
        begin nerr++; $display("FAIL l1_read%0d: done %b data %h want 1 %h", i, done1, rd1, d); end
      nvec++; if (rdy1 !== 1'b0) begin nerr++; $display("FAIL l1_ready_low%0d: got %b want 0", i, rdy1); end
      @(negedge clock);
      nvec++; if (rdy1 !== 1'b1 || done1 !== 1'b0)
        begin nerr++; $display("FAIL l1_after%0d: ready %b done %b want 1 0", i, rdy1, done1); end
    end
  endtask

  task automatic test_full_compare();
    logic [63:0] r;
    int lat;
    for (int w = 0; w < NW; w++) begin
      issue(0, RD, BASE + 64'(w) * 8, 64'd0, 64'd0, r, lat);
      nvec++; if (r !== mem_m[w])
        begin nerr++; $display("FAIL array_word%0d: got %h want %h", w, r, mem_m[w]); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_masked();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_midop();
    test_latency1();
    test_full_compare();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tbus_mem_responder.md
Name: tbus_mem_responder

Overview:
- Responder (target) end of the trinity bus (tbus). It accepts single read/write requests from the load/store unit's tbus initiator.
- Each request is served from a local word-addressed memory array after a fixed, parameterised latency. The result is returned with a one-cycle `tbus_operation_done` pulse.
- Used as the backing data memory for backend simulation and bring-up, standing in for a future dcache.

Parameters:
- DEPTH_LOG, 12, log2 of the number of 64-bit words in the array.
- LATENCY, 2, cycles from request accept edge to the `done` cycle (legal 1..15).
- BASE_ADDR, 64'h8000_0000, byte address of word 0.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tbus_index_valid  in  1  request valid from initiator
- tbus_index_ready  out  1  responder can accept a request
- tbus_index  in  64  request byte address
- tbus_write_data  in  64  store data, already lane-aligned by the initiator
- tbus_write_mask  in  64  bit-level write enable
- tbus_operation_type  in  `TBUS_OPTYPE_RANGE  `TBUS_READ` / `TBUS_WRITE`
- tbus_read_data  out  64  full aligned 64-bit word; valid only while `done`=1
- tbus_operation_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: `tbus_index_ready`=1, `tbus_operation_done`=0, `tbus_read_data`=0, FSM=IDLE, counter=0. Array contents are not reset.
- Accept: fire = `valid & ready`. Inputs are sampled only on fire. Valid while ready=0 is ignored; the initiator must hold or withdraw it.
- Ready is 1 only in IDLE. Only one request is ever outstanding.
- FSM states:
  - IDLE: on fire, latch type, address, data and mask; load cnt=LATENCY-1; go to WAIT (or straight to RESP if LATENCY==1).
  - WAIT: decrement cnt each cycle; when cnt==0 go to RESP.
  - RESP: `done`=1 for exactly this cycle; next state IDLE.
- Latency: fire at the edge ending cycle T gives `done` high in cycle T+LATENCY. Throughput is one request per LATENCY+1 cycles.
- Address decode:
  - off = index - BASE_ADDR (64-bit unsigned).
  - In range iff off < 2^DEPTH_LOG*8.
  - Word index = off[DEPTH_LOG+2:3]. index[2:0] is ignored (the initiator shifts lanes itself).
- Read, in range: during RESP, `read_data` = array[word]. Out of range: `read_data`=0. Outside RESP, `read_data` is driven to 0.
- Write, in range: at the clock edge ending RESP, array[word] <= (old & ~mask) | (data & mask). Out of range: dropped. Writes still pulse `done`; `read_data`=0 during a write's RESP.
- Any other optype: accepted, completes with `done`, no array change, `read_data`=0.
- Read following a write to the same word sees the new data (the write commits before the next accept is possible).
- Reset asserted mid-operation: FSM returns to IDLE immediately; no `done` is produced and a pending write is not committed.
- Initiator-side flush: the responder has no flush input. An accepted request always completes and pulses `done`. The initiator ignores a stale `done` when it is not OUTSTANDING.

Decomposition:
- `TBUS_READ`, `TBUS_WRITE` and `TBUS_OPTYPE_RANGE` stay in the shared defines; add `TBUS_DATA_WIDTH`=64 there.
- FSM state encodings (IDLE/WAIT/RESP) are localparams inside the module.
- One sub-module, `tbus_mem_array`: 2^DEPTH_LOG x 64 flop array with a combinational read port and a bit-masked synchronous write port (we, waddr, wdata, wmask).

Test Plan (LATENCY=2, BASE_ADDR=0x8000_0000):
- Write then read: write 0x8000_0010, data 0x1122334455667788, mask all-ones. `done` in cycle T+2 with `read_data`=0. Then read 0x8000_0010 → `done` at T'+2, `read_data`=0x1122334455667788.
- Masked byte write: preload word 0x8000_0000 with 0xFFFF_FFFF_FFFF_FFFF; write data 0x0000_00AB_0000_0000, mask 0x0000_00FF_0000_0000; read back → 0xFFFF_FFAB_FFFF_FFFF.
- Backpressure: hold valid high for 5 back-to-back reads. Ready must go low in the cycle after each fire and high again one cycle after each `done`. Exactly 5 `done` pulses, spaced 3 cycles apart, each carrying the correct word.
- Out of range: read 0x7FFF_FFF8 → `done` with `read_data`=0. Write 0x8000_0000+2^15 → `done`, no array word changes (full-array compare).
- Reset mid-op: fire a write to 0x8000_0020, assert reset in the WAIT cycle. No `done`; ready=1 after release; a read of 0x8000_0020 returns the old value.
- LATENCY=1 instance: fire read at T → `done` in cycle T+1 with correct data; ready=0 only in that cycle.
